// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART telemetry framer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    HDR   = 3'd2,
    SEQ   = 3'd3,
    DATA  = 3'd4,
    CSUM  = 3'd5,
    GAP   = 3'd6
  } framer_state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Channel words go out as whole bytes, zero-padded at the MSB end.
  function automatic int bytes_per_ch(input int data_w);
    return (data_w + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       serial_tx,
  output logic       ready,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic          busy_q,  busy_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [3:0]    bit_q,   bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q,    tx_d;
  logic          last_cyc_s;

  assign last_cyc_s = (baud_q == BAUD_LAST);
  // done marks the final cycle of the stop bit so a back-to-back start loses no time.
  assign done       = busy_q && last_cyc_s && (bit_q == 4'd9);
  assign ready      = !busy_q || done;
  assign serial_tx  = tx_q;

  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    if (start && ready) begin
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = 4'd0;
      shreg_d = data;
      tx_d    = 1'b0;
    end else if (busy_q) begin
      if (last_cyc_s) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          bit_d  = 4'd0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1 : shreg_q[bit_q[2:0]];
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_telemetry_framer.sv
// Snapshots NUM_CH channel words and streams them as a framed, checksummed 8N1 packet,
// repeating frames with a GAP_CYC idle gap while enabled and the host is ready.
module uart_telemetry_framer
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1085,
  parameter int         NUM_CH       = 4,
  parameter int         DATA_W       = 16,
  parameter logic [7:0] HEADER       = HEADER_BYTE,
  parameter int         GAP_CYC      = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dtr,
  input  logic                     fsm_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     serial_tx,
  output logic                     busy,
  output logic                     byte_done,
  output logic                     frame_done,
  output logic [7:0]               seq_num
);

  localparam int BPC      = bytes_per_ch(DATA_W);
  localparam int PAD_W    = BPC * 8;
  localparam int NBYTES   = NUM_CH * BPC;
  localparam int SW       = NBYTES * 8;
  localparam int IW       = $clog2(NBYTES) + 1;
  localparam int GW       = $clog2(GAP_CYC + 1) + 1;
  // Exiting GAP straight into LATCH costs two cycles before the next start bit.
  localparam int GAP_LAST = (GAP_CYC >= 2) ? GAP_CYC - 2 : 0;

  framer_state_t state_q, state_d;
  logic [SW-1:0] stream_q, stream_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    seq_q, seq_d;
  logic          busy_q, busy_d;
  logic          byte_done_q, byte_done_d;
  logic          frame_done_q, frame_done_d;
  logic          tx_start_s, tx_ready_s, tx_done_s, go_s;
  logic [7:0]    tx_data_s;
  logic [SW-1:0] latch_s;

  // ch0 lands in the top bytes so the frame is sent by shifting the snapshot left.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pad
    assign latch_s[(NUM_CH-1-g)*PAD_W +: PAD_W] = PAD_W'(ch_data[g*DATA_W +: DATA_W]);
  end

  assign go_s = fsm_en && !dtr;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (tx_start_s),
    .data      (tx_data_s),
    .serial_tx (serial_tx),
    .ready     (tx_ready_s),
    .done      (tx_done_s)
  );

  always_comb begin
    state_d      = state_q;
    stream_d     = stream_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    seq_d        = seq_q;
    busy_d       = busy_q;
    byte_done_d  = tx_done_s;
    frame_done_d = 1'b0;
    tx_start_s   = 1'b0;
    tx_data_s    = HEADER;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = LATCH;
          busy_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      LATCH: begin
        stream_d = latch_s;
        idx_d    = '0;
        if (tx_ready_s) begin
          tx_start_s = 1'b1;
          state_d    = HDR;
        end else begin
          state_d = LATCH;
        end
      end
      HDR, SEQ, DATA: begin
        // dtr only matters at byte boundaries; a raised dtr abandons the frame.
        if (tx_done_s && dtr) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tx_done_s) begin
          tx_start_s = 1'b1;
          if (state_q == HDR) begin
            tx_data_s = seq_q;
            state_d   = SEQ;
          end else if (state_q == DATA && idx_q == IW'(NBYTES - 1)) begin
            tx_data_s = 8'h00 - sum_q;
            state_d   = CSUM;
          end else begin
            tx_data_s = stream_q[SW-1 -: 8];
            stream_d  = stream_q << 8;
            idx_d     = (state_q == SEQ) ? '0 : idx_q + IW'(1);
            state_d   = DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      CSUM: begin
        if (tx_done_s) begin
          frame_done_d = 1'b1;
          seq_d        = seq_q + 8'd1;
          busy_d       = 1'b0;
          gap_d        = '0;
          state_d      = (GAP_CYC >= 2) ? GAP : IDLE;
        end else begin
          state_d = CSUM;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = go_s ? LATCH : IDLE;
          busy_d  = go_s;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    sum_d = tx_start_s ? ((state_q == LATCH) ? tx_data_s : sum_q + tx_data_s) : sum_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      stream_q     <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      sum_q        <= 8'h00;
      seq_q        <= 8'h00;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stream_q     <= stream_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      sum_q        <= sum_d;
      seq_q        <= seq_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign byte_done  = byte_done_q;
  assign frame_done = frame_done_q;
  assign seq_num    = seq_q;

endmodule
